// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register with valid/ready handshake, flush and immediate-extender op decode.
// Define IF_ID_SKID_EN for a 2-entry skid buffer (registered in_ready); default is a single register.

`ifndef EXT_OP_SE
`define EXT_OP_SE 2'b00
`endif
`ifndef EXT_OP_ZE
`define EXT_OP_ZE 2'b01
`endif
`ifndef EXT_OP_LS
`define EXT_OP_LS 2'b10
`endif

// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holds valid and its payload stable until that transfer, and valid never
// depends on ready. flush overrides any same-cycle input transfer.
module if_id_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [15:0] out_im,
  output logic [1:0]  out_ext_op
);

  function automatic logic [1:0] ext_decode(input logic [5:0] opcode);
    logic [1:0] op;
    op = `EXT_OP_SE;
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: op = `EXT_OP_ZE;
      6'h0F:               op = `EXT_OP_LS;
      default:             op = `EXT_OP_SE;
    endcase
    return op;
  endfunction

  logic        main_valid;
  logic [31:0] main_pc;
  logic [31:0] main_instr;
  logic [1:0]  main_ext;
  logic [1:0]  in_ext;
  logic        accept;
  logic        consume;

  assign in_ext  = ext_decode(in_instr[31:26]);
  assign accept  = in_valid & in_ready & ~flush;
  assign consume = main_valid & out_ready;

`ifdef IF_ID_SKID_EN
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [1:0]  skid_ext;

  // Ready depends only on skid occupancy, so no combinational path from out_ready.
  assign in_ready = ~skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_pc    <= PC_RESET;
      skid_instr <= NOP_INSTR;
      skid_ext   <= `EXT_OP_SE;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (consume && skid_valid) begin
      skid_valid <= 1'b0;
    end else if (main_valid && !out_ready && accept) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_instr <= in_instr;
      skid_ext   <= in_ext;
    end
  end
`else
  assign in_ready = ~main_valid | out_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_pc    <= PC_RESET;
      main_instr <= NOP_INSTR;
      main_ext   <= `EXT_OP_SE;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_pc    <= PC_RESET;
      main_instr <= NOP_INSTR;
      main_ext   <= `EXT_OP_SE;
`ifdef IF_ID_SKID_EN
    end else if (consume && skid_valid) begin
      main_pc    <= skid_pc;
      main_instr <= skid_instr;
      main_ext   <= skid_ext;
`endif
    end else if (!main_valid || out_ready) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_pc    <= in_pc;
        main_instr <= in_instr;
        main_ext   <= in_ext;
      end else if (consume) begin
        // Drained: keep the last PC but show a NOP so decode never sees stale fields.
        main_valid <= 1'b0;
        main_instr <= NOP_INSTR;
        main_ext   <= `EXT_OP_SE;
      end
    end
  end

  assign out_valid  = main_valid;
  assign out_pc     = main_pc;
  assign out_instr  = main_instr;
  assign out_ext_op = main_ext;
  assign out_rs     = main_instr[25:21];
  assign out_rt     = main_instr[20:16];
  assign out_rd     = main_instr[15:11];
  assign out_im     = main_instr[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed + random bench for if_id_stage with a queue scoreboard on the decode side.
// Stall/flush steps adapt to whether IF_ID_SKID_EN is defined.
module tb_if_id_stage;

  localparam logic [1:0] SE = 2'b00;
  localparam logic [1:0] ZE = 2'b01;
  localparam logic [1:0] LS = 2'b10;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [15:0] out_im;
  logic [1:0]  out_ext_op;

  int vectors;
  int miscompares;
  logic [65:0] exp_q[$];

  if_id_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_im(out_im),
    .out_ext_op(out_ext_op)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] model_ext(input logic [31:0] instr);
    logic [5:0] opc;
    opc = instr[31:26];
    if (opc == 6'h0F) return LS;
    if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E) return ZE;
    return SE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop on consume, push on accept, both sampled at negedge
  always @(negedge clk) begin
    logic [65:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("out_has_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_pc", out_pc, e[65:34]);
          check("sb_instr", out_instr, e[33:2]);
          check("sb_ext", {30'd0, out_ext_op}, {30'd0, e[1:0]});
          check("sb_rs", {27'd0, out_rs}, {27'd0, e[27:23]});
          check("sb_rt", {27'd0, out_rt}, {27'd0, e[22:18]});
          check("sb_rd", {27'd0, out_rd}, {27'd0, e[17:13]});
          check("sb_im", {16'd0, out_im}, {16'd0, e[17:2]});
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_pc, in_instr, model_ext(in_instr)});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_pc"}, out_pc, 32'h0000_3000);
    check({tag, "_instr"}, out_instr, 32'h0);
    check({tag, "_ext"}, {30'd0, out_ext_op}, {30'd0, SE});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  logic [31:0] step3_instr[3] = '{32'h3C01_1234, 32'h2421_8000, 32'h3021_0001};
  logic [1:0]  step3_ext[3]   = '{LS, SE, ZE};
  logic [5:0]  ops[7]         = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h09, 6'h00, 6'h23};

  initial begin
    logic        acc;
    logic [31:0] pc_ctr;
    logic [25:0] low;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // reset values
    tick();
    check_idle_reset("reset");
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;

    // ori stream
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_3000, 32'h3400_FFFF);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("ori_valid", {31'd0, out_valid}, 32'd1);
    check("ori_im", {16'd0, out_im}, 32'h0000_FFFF);
    check("ori_ext", {30'd0, out_ext_op}, {30'd0, ZE});
    tick();

    // back-to-back decode of lui / addiu / andi
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3004 + 32'(4 * i), step3_instr[i]);
      tick();
      check("dec_valid", {31'd0, out_valid}, 32'd1);
      check("dec_pc", out_pc, 32'h0000_3004 + 32'(4 * i));
      check("dec_ext", {30'd0, out_ext_op}, {30'd0, step3_ext[i]});
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    check("drained_instr", out_instr, 32'h0);
    check("drained_ext", {30'd0, out_ext_op}, {30'd0, SE});

    // stall
    out_ready = 1'b0;
`ifdef IF_ID_SKID_EN
    drive(1'b1, 32'h0000_4000, 32'h3C02_AAAA);
    tick();
    drive(1'b1, 32'h0000_4004, 32'h3402_5555);
    check("stall_ready_1st", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 32'h0000_4008, 32'h2402_0001);
    check("stall_ready_full", {31'd0, in_ready}, 32'd0);
    check("stall_hold_pc", out_pc, 32'h0000_4000);
    tick();
    check("stall_ready_full2", {31'd0, in_ready}, 32'd0);
    tick();
    check("stall_hold_pc2", out_pc, 32'h0000_4000);
    out_ready = 1'b1;
    tick();
    check("release_pc_b", out_pc, 32'h0000_4004);
    check("release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("release_pc_c", out_pc, 32'h0000_4008);
    drive(1'b0, 32'h0, 32'h0);
    wait_drain();
`else
    drive(1'b1, 32'h0000_4000, 32'h3C02_AAAA);
    tick();
    drive(1'b1, 32'h0000_4004, 32'h3402_5555);
    #1;
    check("ns_stall_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    check("ns_hold_pc", out_pc, 32'h0000_4000);
    out_ready = 1'b1;
    #1;
    check("ns_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("ns_next_pc", out_pc, 32'h0000_4004);
    drive(1'b0, 32'h0, 32'h0);
    wait_drain();
`endif

    // flush with held entries and an incoming one
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_5000, 32'h3403_0001);
    tick();
`ifdef IF_ID_SKID_EN
    drive(1'b1, 32'h0000_5004, 32'h3403_0002);
    tick();
`endif
    drive(1'b1, 32'h0000_5008, 32'h3403_0003);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_idle_reset("flush");
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("flush_no_output", {31'd0, out_valid}, 32'd0);

    // mid-stream asynchronous reset
    drive(1'b1, 32'h0000_6000, 32'h3C04_0001);
    tick();
    drive(1'b1, 32'h0000_6004, 32'h3C04_0002);
    #2;
    rst = 1'b1;
    #1;
    check_idle_reset("midrst");
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h0000_7000, 32'h3005_00FF);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("postrst_valid", {31'd0, out_valid}, 32'd1);
    check("postrst_pc", out_pc, 32'h0000_7000);
    tick();

    // random traffic with back-pressure
    acc = 1'b0;
    pc_ctr = 32'h0000_8000;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        low = 26'($urandom());
        drive($urandom_range(0, 2) != 0, pc_ctr, {ops[$urandom_range(0, 6)], low});
        pc_ctr = pc_ctr + 32'd4;
      end
      #1;
      acc = in_valid && in_ready;
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
